// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types; ramstate_t is the handshake state seen by memory_control.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage

// File: rtl/ram_ctrl.sv
// Word-addressed main-memory back end behind memory_control: programmable access
// latency, restart on request change, illegal-request ERROR state and a preload port.
module ram_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   ramaddr,
  input  logic          ramREN,
  input  logic          ramWEN,
  input  logic [31:0]   ramstore,
  output logic [31:0]   ramload,
  output ramstate_t     ramstate,
  input  logic          ldWEN,
  input  logic [AW-1:0] ldaddr,
  input  logic [31:0]   ldstore
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);

  logic [31:0]   mem [DEPTH];

  // Latched transaction and wait counter
  logic [31:0]   lat_addr;
  logic          lat_ren;
  logic          lat_wen;
  logic [31:0]   lat_store;
  logic [CW-1:0] cnt;

  logic [AW-1:0] idx_live;
  logic [AW-1:0] lat_idx;
  logic          illegal;
  logic          start;
  logic          idle;
  logic          changed;
  logic          ld_hit;

  assign idx_live = ramaddr[AW+1:2];
  assign lat_idx  = lat_addr[AW+1:2];
  assign illegal  = (ramREN & ramWEN) |
                    ((ramREN | ramWEN) & (ramaddr[31:AW+2] != '0));
  assign start    = (ramREN ^ ramWEN) & ~illegal;
  assign idle     = ~ramREN & ~ramWEN;
  assign changed  = (ramaddr != lat_addr) | (ramREN != lat_ren) |
                    (ramWEN != lat_wen) | (ramstore != lat_store);
  assign ld_hit   = ldWEN & (ldaddr == lat_idx);

  // Request FSM: latch, count down the latency, present one ACCESS cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      ramstate  <= FREE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_ren   <= 1'b0;
      lat_wen   <= 1'b0;
      lat_store <= '0;
      ramload   <= '0;
    end else begin
      unique case (ramstate)
        BUSY: begin
          if (illegal) begin
            ramstate <= ERROR;
          end else if (idle) begin
            ramstate <= FREE;
          end else if (changed) begin
            lat_addr  <= ramaddr;
            lat_ren   <= ramREN;
            lat_wen   <= ramWEN;
            lat_store <= ramstore;
            cnt       <= LAT_C;
          end else if (ld_hit) begin
            cnt <= LAT_C;
          end else if (cnt <= CW'(1)) begin
            ramstate <= ACCESS;
            if (lat_ren) begin
              ramload <= mem[lat_idx];
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          // FREE, ACCESS and ERROR all treat the live request as a new transaction
          if (illegal) begin
            ramstate <= ERROR;
          end else if (start) begin
            lat_addr  <= ramaddr;
            lat_ren   <= ramREN;
            lat_wen   <= ramWEN;
            lat_store <= ramstore;
            cnt       <= LAT_C;
            if (LAT == 0) begin
              ramstate <= ACCESS;
              if (ramREN) begin
                ramload <= mem[idx_live];
              end
            end else begin
              ramstate <= BUSY;
            end
          end else begin
            ramstate <= FREE;
          end
        end
      endcase
    end
  end

  // Memory array: preload always wins over a same-index commit leaving ACCESS
  always_ff @(posedge CLK) begin
    if (ldWEN) begin
      mem[ldaddr] <= ldstore;
    end
    if (!RST && (ramstate == ACCESS) && lat_wen && !ld_hit) begin
      mem[lat_idx] <= lat_store;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: one LAT=2 instance and one LAT=0 instance on shared stimulus.
module tb_ram_ctrl;
  import cpu_types_pkg::*;

  localparam int unsigned AW = 12;

  logic          CLK = 1'b0;
  logic          RST;
  logic [31:0]   ramaddr;
  logic          ramREN;
  logic          ramWEN;
  logic [31:0]   ramstore;
  logic          ldWEN;
  logic [AW-1:0] ldaddr;
  logic [31:0]   ldstore;
  logic [31:0]   ramload;
  ramstate_t     ramstate;
  logic [31:0]   ramload0;
  ramstate_t     ramstate0;

  int n_tests = 0;
  int n_fail  = 0;

  ram_ctrl #(.LAT(2), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .ramaddr(ramaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .ldWEN(ldWEN), .ldaddr(ldaddr), .ldstore(ldstore)
  );

  ram_ctrl #(.LAT(0), .AW(AW)) dut0 (
    .CLK(CLK), .RST(RST), .ramaddr(ramaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramstore(ramstore), .ramload(ramload0), .ramstate(ramstate0),
    .ldWEN(ldWEN), .ldaddr(ldaddr), .ldstore(ldstore)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ramREN   = r;
    ramWEN   = w;
    ramaddr  = a;
    ramstore = d;
  endtask

  task automatic preload(input logic [AW-1:0] idx, input logic [31:0] data);
    ldWEN   = 1'b1;
    ldaddr  = idx;
    ldstore = data;
    tick();
    ldWEN   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    req(1'b0, 1'b0, 32'h0, 32'h0);
    ldWEN = 1'b0; ldaddr = '0; ldstore = '0;
    tick(); tick();
    chk("rst_state",   32'(ramstate),  32'(FREE));
    chk("rst_load",    ramload,        32'h0);
    chk("rst_state0",  32'(ramstate0), 32'(FREE));
    RST = 1'b0;

    // Write 0xDEADBEEF to 0x40, held until ACCESS
    req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    chk("wr_t0", 32'(ramstate), 32'(FREE));
    tick(); chk("wr_t1", 32'(ramstate), 32'(BUSY));
    tick(); chk("wr_t2", 32'(ramstate), 32'(BUSY));
    tick(); chk("wr_t3", 32'(ramstate), 32'(ACCESS));
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); chk("wr_t4", 32'(ramstate), 32'(FREE));

    // Read back 0x40
    req(1'b1, 1'b0, 32'h40, 32'h0);
    tick(); chk("rd40_t1", 32'(ramstate), 32'(BUSY));
    tick(); chk("rd40_t2", 32'(ramstate), 32'(BUSY));
    tick(); chk("rd40_t3", 32'(ramstate), 32'(ACCESS));
    chk("rd40_data", ramload, 32'hDEADBEEF);
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); chk("rd40_free", 32'(ramstate), 32'(FREE));
    chk("rd40_hold", ramload, 32'hDEADBEEF);

    preload(AW'(5),  32'h0000_1234);
    preload(AW'(6),  32'h6666_0006);
    preload(AW'(7),  32'h0000_7777);
    preload(AW'(32), 32'h5555_AAAA);

    // Read preloaded word 5
    req(1'b1, 1'b0, 32'h14, 32'h0);
    tick(); chk("rd14_t1", 32'(ramstate), 32'(BUSY));
    chk("rd14_hold", ramload, 32'hDEADBEEF);
    tick(); chk("rd14_t2", 32'(ramstate), 32'(BUSY));
    tick(); chk("rd14_t3", 32'(ramstate), 32'(ACCESS));
    chk("rd14_data", ramload, 32'h0000_1234);
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); chk("rd14_free", 32'(ramstate), 32'(FREE));

    // Address change 0x14 -> 0x18 in the second BUSY cycle restarts the count
    req(1'b1, 1'b0, 32'h14, 32'h0);
    tick(); tick();
    chk("chg_busy2", 32'(ramstate), 32'(BUSY));
    req(1'b1, 1'b0, 32'h18, 32'h0);
    tick(); chk("chg_c1", 32'(ramstate), 32'(BUSY));
    tick(); chk("chg_c2", 32'(ramstate), 32'(BUSY));
    tick(); chk("chg_c3", 32'(ramstate), 32'(ACCESS));
    chk("chg_data", ramload, 32'h6666_0006);
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); chk("chg_free", 32'(ramstate), 32'(FREE));

    // Both enables high for 4 cycles
    req(1'b1, 1'b1, 32'h14, 32'h0000_0BAD);
    for (int i = 1; i <= 4; i++) begin
      tick(); chk($sformatf("err_%0d", i), 32'(ramstate), 32'(ERROR));
    end
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); chk("err_free", 32'(ramstate), 32'(FREE));
    req(1'b1, 1'b0, 32'h14, 32'h0);
    tick(); tick(); tick();
    chk("err_unch_st", 32'(ramstate), 32'(ACCESS));
    chk("err_unch",    ramload, 32'h0000_1234);
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Address beyond the array is illegal
    req(1'b1, 1'b0, 32'h0001_0014, 32'h0);
    tick(); chk("oor_err", 32'(ramstate), 32'(ERROR));
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); chk("oor_free", 32'(ramstate), 32'(FREE));

    // Reset during BUSY of a write drops it
    req(1'b0, 1'b1, 32'h80, 32'h0BAD_F00D);
    tick(); chk("rstw_busy", 32'(ramstate), 32'(BUSY));
    RST = 1'b1;
    tick();
    chk("rstw_state", 32'(ramstate), 32'(FREE));
    chk("rstw_load",  ramload,  32'h0);
    chk("rstw_load0", ramload0, 32'h0);
    RST = 1'b0;
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); chk("rstw_free", 32'(ramstate), 32'(FREE));
    req(1'b1, 1'b0, 32'h80, 32'h0);
    tick(); tick(); tick();
    chk("rstw_rd_st", 32'(ramstate), 32'(ACCESS));
    chk("rstw_mem",   ramload, 32'h5555_AAAA);
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // LAT=0: held read is a new transaction every cycle
    chk("l0_t0", 32'(ramstate0), 32'(FREE));
    req(1'b1, 1'b0, 32'h1C, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("l0_st%0d", i), 32'(ramstate0), 32'(ACCESS));
      chk($sformatf("l0_d%0d", i),  ramload0, 32'h0000_7777);
    end
    req(1'b1, 1'b0, 32'h14, 32'h0);
    tick(); chk("l0_chg14", ramload0, 32'h0000_1234);
    req(1'b1, 1'b0, 32'h18, 32'h0);
    tick(); chk("l0_chg18", ramload0, 32'h6666_0006);
    chk("l0_chg_st", 32'(ramstate0), 32'(ACCESS));
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); chk("l0_free", 32'(ramstate0), 32'(FREE));
    tick(); tick();
    chk("settle", 32'(ramstate), 32'(FREE));

    // Preload hitting the latched index in BUSY restarts the count
    req(1'b1, 1'b0, 32'h1C, 32'h0);
    tick(); tick();
    ldWEN = 1'b1; ldaddr = AW'(7); ldstore = 32'h0000_ABCD;
    tick();
    ldWEN = 1'b0;
    chk("ld_c1", 32'(ramstate), 32'(BUSY));
    tick(); chk("ld_c2", 32'(ramstate), 32'(BUSY));
    tick(); chk("ld_c3", 32'(ramstate), 32'(ACCESS));
    chk("ld_data", ramload, 32'h0000_ABCD);
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); chk("ld_free", 32'(ramstate), 32'(FREE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
